// File: rtl/simple_alu_pkg.sv
// Shared constants and opcode encoding for the simple_alu datapath.
package simple_alu_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_PASSA = 2'd2,
        OP_PASSB = 2'd3
    } opcode_e;

endpackage : simple_alu_pkg

// File: rtl/simple_alu_addsub.sv
// WIDTH-bit adder/subtractor: sub=1 computes a - b as a + ~b + 1, carry/borrow dropped.
module simple_alu_addsub #(
    parameter int WIDTH = simple_alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] carry_in;

    assign b_eff    = sub ? ~b_i : b_i;
    assign carry_in = {{(WIDTH-1){1'b0}}, sub};
    assign result_o = a_i + b_eff + carry_in;

endmodule : simple_alu_addsub

// File: rtl/simple_alu.sv
// 4-function ALU (add, sub, pass A, pass B); purely combinational, clock/reset present for port uniformity.
module simple_alu
    import simple_alu_pkg::*;
#(
    parameter int WIDTH = simple_alu_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       io_opcode,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic [WIDTH-1:0] io_out
);

    opcode_e          op;
    logic [WIDTH-1:0] addsub_result;
    logic             unused_clock_reset;

    // No state lives here; clock and reset are deliberately left unconnected to logic.
    assign unused_clock_reset = clock | reset;

    assign op = opcode_e'(io_opcode);

    simple_alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i      (io_a),
        .b_i      (io_b),
        .sub      (op == OP_SUB),
        .result_o (addsub_result)
    );

    always_comb begin
        io_out = io_b;
        case (op)
            OP_ADD,
            OP_SUB:   io_out = addsub_result;
            OP_PASSA: io_out = io_a;
            default:  io_out = io_b;
        endcase
    end

endmodule : simple_alu

// File: tb/tb_simple_alu.sv
// Directed and exhaustive checks of simple_alu against hand-computed values and a mod-16 model.
module tb_simple_alu;

    logic       clock;
    logic       reset;
    logic [1:0] io_opcode;
    logic [3:0] io_a;
    logic [3:0] io_b;
    logic [3:0] io_out;

    int tests_run;
    int tests_failed;

    simple_alu #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_opcode (io_opcode),
        .io_a      (io_a),
        .io_b      (io_b),
        .io_out    (io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_and_check(input string tag, input logic [1:0] op,
                                   input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] exp);
        @(negedge clock);
        io_opcode = op;
        io_a      = a;
        io_b      = b;
        #2;
        $display("[TB] %s op=%0d a=%0d b=%0d out=%0d exp=%0d", tag, op, a, b, io_out, exp);
        check_eq(tag, io_out, exp);
    endtask

    function automatic logic [3:0] ref_model(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (a + b) % 16;
            1:       r = (a - b + 16) % 16;
            2:       r = a;
            default: r = b;
        endcase
        return r[3:0];
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        io_opcode    = 2'd0;
        io_a         = 4'd0;
        io_b         = 4'd0;
        #2;
        check_eq("in_reset_add_0_0", io_out, 4'd0);
        io_a = 4'd3;
        io_b = 4'd4;
        #1;
        check_eq("in_reset_add_3_4", io_out, 4'd7);
        @(negedge clock);
        reset = 1'b0;

        apply_and_check("add_3_4",    2'd0, 4'd3,  4'd4,  4'd7);
        apply_and_check("add_0_0",    2'd0, 4'd0,  4'd0,  4'd0);
        apply_and_check("add_15_1",   2'd0, 4'd15, 4'd1,  4'd0);
        apply_and_check("add_9_9",    2'd0, 4'd9,  4'd9,  4'd2);
        apply_and_check("sub_7_2",    2'd1, 4'd7,  4'd2,  4'd5);
        apply_and_check("sub_2_7",    2'd1, 4'd2,  4'd7,  4'd11);
        apply_and_check("sub_0_1",    2'd1, 4'd0,  4'd1,  4'd15);
        apply_and_check("passa_10_5", 2'd2, 4'd10, 4'd5,  4'd10);
        apply_and_check("passb_10_5", 2'd3, 4'd10, 4'd5,  4'd5);
        apply_and_check("sub_15_15",  2'd1, 4'd15, 4'd15, 4'd0);
        // Opcode and operands change together.
        apply_and_check("chg_all",    2'd2, 4'd1,  4'd14, 4'd1);

        apply_and_check("rst_hold",   2'd0, 4'd6,  4'd3,  4'd9);
        #1;
        reset = 1'b1;
        #1;
        $display("[TB] reset asserted out=%0d", io_out);
        check_eq("rst_assert", io_out, 4'd9);
        @(posedge clock);
        #1;
        $display("[TB] reset held over edge out=%0d", io_out);
        check_eq("rst_over_edge", io_out, 4'd9);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        $display("[TB] reset deasserted out=%0d", io_out);
        check_eq("rst_deassert", io_out, 4'd9);

        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    apply_and_check("sweep", op[1:0], a[3:0], b[3:0], ref_model(op, a, b));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_simple_alu
